// File: rtl/counter_cmd_ctrl_if.sv
// Command handshake between a command source and counter_cmd_ctrl.
//   cmd_valid : source has a command on cmd_op / cmd_arg
//   cmd_ready : sequencer can take a command this cycle
//   cmd_op    : 00 LOAD, 01 UP, 10 DOWN, 11 HOLD
//   cmd_arg   : LOAD value, or step/cycle count for UP/DOWN/HOLD
// master = command source, slave = sequencer.
interface counter_cmd_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_arg;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        output cmd_ready
    );
endinterface

// File: rtl/counter_cmd_ctrl.sv
// Command sequencer for a WIDTH-bit up/down counter. Expands LOAD / UP /
// DOWN / HOLD commands into per-cycle load_n / ce / up_down / data_load
// controls and optionally saturates on the counter's max_count / zero flags.
//   clk, rst_n          : clock, asynchronous active-low reset
//   cmd (slave)         : valid/ready command port
//   max_count, zero     : counter status flags
//   load_n, ce, up_down : counter controls
//   data_load           : counter load value
//   busy                : command in progress
//   done                : one-cycle pulse, final counter value visible
//   sat_hit             : one-cycle pulse with done, command cut short by saturation
module counter_cmd_ctrl #(
    parameter int WIDTH    = 4,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    counter_cmd_ctrl_if.slave cmd,
    input  logic             max_count,
    input  logic             zero,
    output logic             load_n,
    output logic             ce,
    output logic             up_down,
    output logic [WIDTH-1:0] data_load,
    output logic             busy,
    output logic             done,
    output logic             sat_hit
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_HOLD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] arg_q, arg_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             sat_hit_q, sat_hit_d;

    logic accept;
    logic run;
    logic sat;
    logic last;

    assign accept = cmd.cmd_valid && cmd.cmd_ready;
    assign run    = (state_q == S_RUN);

    // The only combinational input path: flags gate ce in the same cycle,
    // so the step that would cross the boundary is never issued.
    assign sat  = SATURATE && run &&
                  (((op_q == OP_UP) && max_count) || ((op_q == OP_DOWN) && zero));
    assign last = run && ((rem_q == WIDTH'(1)) || sat);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_LOAD;
            arg_q     <= '0;
            rem_q     <= '0;
            done_q    <= 1'b0;
            sat_hit_q <= 1'b0;
        end else begin
            op_q      <= op_d;
            arg_q     <= arg_d;
            rem_q     <= rem_d;
            done_q    <= done_d;
            sat_hit_q <= sat_hit_d;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        arg_d     = arg_q;
        rem_d     = rem_q;
        done_d    = 1'b0;
        sat_hit_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d  = cmd.cmd_op;
                    arg_d = cmd.cmd_arg;
                    if (cmd.cmd_op == OP_LOAD) begin
                        state_d = S_LOAD;
                    end else if (cmd.cmd_arg != '0) begin
                        state_d = S_RUN;
                        rem_d   = cmd.cmd_arg;
                    end else begin
                        // Zero-length count: complete without touching the counter.
                        done_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            S_RUN: begin
                rem_d = rem_q - WIDTH'(1);
                if (last) begin
                    state_d   = S_IDLE;
                    rem_d     = '0;
                    done_d    = 1'b1;
                    sat_hit_d = sat;
                end
            end
            default: begin
                state_d = S_IDLE;
                rem_d   = '0;
            end
        endcase
    end

    // Output decode from registered state
    always_comb begin
        load_n    = 1'b1;
        ce        = 1'b0;
        up_down   = 1'b0;
        data_load = '0;
        unique case (state_q)
            S_LOAD: begin
                load_n    = 1'b0;
                data_load = arg_q;
            end
            S_RUN: begin
                up_down = (op_q == OP_UP);
                ce      = (op_q != OP_HOLD) && !sat;
            end
            default: ;
        endcase
    end

    assign busy          = (state_q != S_IDLE);
    assign cmd.cmd_ready = !busy;
    assign done          = done_q;
    assign sat_hit       = sat_hit_q;

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// Drives the same command stream into a saturating (index 0) and a wrapping
// (index 1) sequencer, each in front of its own behavioural 4-bit counter.
module tb_counter_cmd_ctrl;

    localparam logic [1:0] LD = 2'b00, UP = 2'b01, DN = 2'b10, HD = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic [1:0] op = 2'b00;
    logic [3:0] arg = 4'h0;

    logic       rdy[2], ldn[2], cew[2], udw[2], bsy[2], dnw[2], stw[2];
    logic [3:0] dlw[2], cnt[2];

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        counter_cmd_ctrl_if #(.WIDTH(4)) cif ();
        logic [3:0] cq;
        logic       mx, zr;

        assign cif.cmd_valid = valid;
        assign cif.cmd_op    = op;
        assign cif.cmd_arg   = arg;
        assign rdy[g]        = cif.cmd_ready;
        assign cnt[g]        = cq;
        assign mx            = (cq == 4'hF);
        assign zr            = (cq == 4'h0);

        counter_cmd_ctrl #(.WIDTH(4), .SATURATE(g == 0)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .cmd       (cif.slave),
            .max_count (mx),
            .zero      (zr),
            .load_n    (ldn[g]),
            .ce        (cew[g]),
            .up_down   (udw[g]),
            .data_load (dlw[g]),
            .busy      (bsy[g]),
            .done      (dnw[g]),
            .sat_hit   (stw[g])
        );

        // Reference 4-bit up/down counter sharing the reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)       cq <= 4'h0;
            else if (!ldn[g]) cq <= dlw[g];
            else if (cew[g])  cq <= udw[g] ? cq + 4'h1 : cq - 4'h1;
        end
    end

    typedef struct {
        logic [1:0] op;
        logic [3:0] arg;
        int         lat0, lat1;
        int         ce0, ce1;
        int         sat0, sat1;
        logic [3:0] cnt0, cnt1;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(input logic [1:0] o, input logic [3:0] a,
                                input int l0, input int l1, input int c0, input int c1,
                                input int s0, input int s1,
                                input logic [3:0] n0, input logic [3:0] n1);
        vec_t v;
        v.op = o; v.arg = a; v.lat0 = l0; v.lat1 = l1; v.ce0 = c0; v.ce1 = c1;
        v.sat0 = s0; v.sat1 = s1; v.cnt0 = n0; v.cnt1 = n1;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_rst(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s load_n[%0d]", tag, i), int'(ldn[i]), 1);
            chk($sformatf("%s ce[%0d]", tag, i), int'(cew[i]), 0);
            chk($sformatf("%s up_down[%0d]", tag, i), int'(udw[i]), 0);
            chk($sformatf("%s data_load[%0d]", tag, i), int'(dlw[i]), 0);
            chk($sformatf("%s busy[%0d]", tag, i), int'(bsy[i]), 0);
            chk($sformatf("%s done[%0d]", tag, i), int'(dnw[i]), 0);
            chk($sformatf("%s sat_hit[%0d]", tag, i), int'(stw[i]), 0);
        end
    endtask

    // Issue one command, watch both sequencers until done (bounded), then
    // compare latency, step count, load activity, saturation and final count.
    task automatic run_vec(input int idx, input vec_t v);
        int         lat[2], cec[2], ldc[2], satc[2], udbad[2];
        logic [3:0] ldv[2], cat[2];
        logic       rat[2];
        bit         fin[2];
        for (int i = 0; i < 2; i++) begin
            lat[i] = 0; cec[i] = 0; ldc[i] = 0; satc[i] = 0; udbad[i] = 0;
            ldv[i] = 4'h0; cat[i] = 4'h0; rat[i] = 1'b0; fin[i] = 1'b0;
        end
        @(negedge clk);
        valid = 1'b1; op = v.op; arg = v.arg;
        @(negedge clk);
        valid = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!fin[i]) begin
                    if (stw[i]) satc[i]++;
                    if (dnw[i]) begin
                        fin[i] = 1'b1; lat[i] = cyc; cat[i] = cnt[i]; rat[i] = rdy[i];
                    end else begin
                        if (cew[i]) cec[i]++;
                        if (!ldn[i]) begin ldc[i]++; ldv[i] = dlw[i]; end
                        if (udw[i] != (bsy[i] && v.op == UP)) udbad[i]++;
                    end
                end
            end
            if (fin[0] && fin[1]) break;
            @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            string t;
            t = $sformatf("v%0d[%0d]", idx, i);
            chk({t, " done latency"}, lat[i], i == 0 ? v.lat0 : v.lat1);
            chk({t, " ce cycles"}, cec[i], i == 0 ? v.ce0 : v.ce1);
            chk({t, " sat_hit"}, satc[i], i == 0 ? v.sat0 : v.sat1);
            chk({t, " count"}, int'(cat[i]), int'(i == 0 ? v.cnt0 : v.cnt1));
            chk({t, " load cycles"}, ldc[i], (v.op == LD) ? 1 : 0);
            chk({t, " ready at done"}, int'(rat[i]), 1);
            chk({t, " up_down"}, udbad[i], 0);
            if (v.op == LD) chk({t, " data_load"}, int'(ldv[i]), int'(v.arg));
        end
    endtask

    initial begin
        int dcount;
        // inst 0 saturates, inst 1 wraps; counts carry across vectors.
        tbl[0]  = mk(LD, 4'h9, 2, 2, 0, 0, 0, 0, 4'h9, 4'h9);
        tbl[1]  = mk(LD, 4'h3, 2, 2, 0, 0, 0, 0, 4'h3, 4'h3);
        tbl[2]  = mk(UP, 4'h5, 6, 6, 5, 5, 0, 0, 4'h8, 4'h8);
        tbl[3]  = mk(LD, 4'hD, 2, 2, 0, 0, 0, 0, 4'hD, 4'hD);
        tbl[4]  = mk(UP, 4'h6, 4, 7, 2, 6, 1, 0, 4'hF, 4'h3);
        tbl[5]  = mk(LD, 4'h2, 2, 2, 0, 0, 0, 0, 4'h2, 4'h2);
        tbl[6]  = mk(DN, 4'h4, 4, 5, 2, 4, 1, 0, 4'h0, 4'hE);
        tbl[7]  = mk(LD, 4'hE, 2, 2, 0, 0, 0, 0, 4'hE, 4'hE);
        tbl[8]  = mk(UP, 4'h3, 3, 4, 1, 3, 1, 0, 4'hF, 4'h1);
        tbl[9]  = mk(HD, 4'h4, 5, 5, 0, 0, 0, 0, 4'hF, 4'h1);
        tbl[10] = mk(UP, 4'h0, 1, 1, 0, 0, 0, 0, 4'hF, 4'h1);
        tbl[11] = mk(DN, 4'h1, 2, 2, 1, 1, 0, 0, 4'hE, 4'h0);
        tbl[12] = mk(DN, 4'h2, 2, 3, 0, 2, 1, 0, 4'h0, 4'hE);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_rst("reset");
        chk("reset ready[0]", int'(rdy[0]), 1);
        chk("reset ready[1]", int'(rdy[1]), 1);

        for (int k = 0; k < 13; k++) begin
            // vector 12 starts from a loaded zero
            if (k == 12) run_vec(100, mk(LD, 4'h0, 2, 2, 0, 0, 0, 0, 4'h0, 4'h0));
            run_vec(k, tbl[k]);
        end

        // Back-to-back: LOAD held valid while UP 2 is busy, accepted on done.
        run_vec(101, mk(LD, 4'h3, 2, 2, 0, 0, 0, 0, 4'h3, 4'h3));
        @(negedge clk);
        valid = 1'b1; op = UP; arg = 4'h2;
        @(negedge clk);
        op = LD; arg = 4'h9;
        @(negedge clk);
        for (int i = 0; i < 2; i++) chk($sformatf("b2b ignored load_n[%0d]", i), int'(ldn[i]), 1);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("b2b done[%0d]", i), int'(dnw[i]), 1);
            chk($sformatf("b2b ready[%0d]", i), int'(rdy[i]), 1);
            chk($sformatf("b2b count[%0d]", i), int'(cnt[i]), 5);
        end
        @(negedge clk);
        valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("b2b load_n[%0d]", i), int'(ldn[i]), 0);
            chk($sformatf("b2b data_load[%0d]", i), int'(dlw[i]), 9);
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("b2b done2[%0d]", i), int'(dnw[i]), 1);
            chk($sformatf("b2b count2[%0d]", i), int'(cnt[i]), 9);
        end

        // Reset mid-RUN: UP 10 from 2, abort after 3 steps.
        run_vec(102, mk(LD, 4'h2, 2, 2, 0, 0, 0, 0, 4'h2, 4'h2));
        @(negedge clk);
        valid = 1'b1; op = UP; arg = 4'hA;
        @(negedge clk);
        valid = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("mid-run count[%0d]", i), int'(cnt[i]), 5);
            chk($sformatf("mid-run ce[%0d]", i), int'(cew[i]), 1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk_rst("abort");
        dcount = 0;
        repeat (3) begin
            @(negedge clk);
            if (dnw[0] || dnw[1]) dcount++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (dnw[0] || dnw[1]) dcount++;
        end
        chk("abort no done", dcount, 0);
        chk("abort ready[0]", int'(rdy[0]), 1);
        chk("abort count[1]", int'(cnt[1]), 0);
        run_vec(103, mk(LD, 4'h7, 2, 2, 0, 0, 0, 0, 4'h7, 4'h7));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/counter_cmd_ctrl.md
# counter_cmd_ctrl

Command sequencer that sits directly upstream of the 4-bit up/down counter and drives its control inputs. It accepts LOAD / UP / DOWN / HOLD commands over a valid/ready handshake and expands each into a cycle-accurate sequence of `load_n`, `ce`, `up_down` and `data_load` values. It watches the counter's `max_count` / `zero` flags to optionally saturate instead of wrapping. It reports completion with a `done` pulse aligned to the cycle in which the counter's final value is visible.

## Interface
- `WIDTH`, 4, counter data width; also the width of `cmd_arg`.
- `SATURATE`, 1, 1 = stop UP at max and DOWN at zero; 0 = allow wrap-around.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset; shared with the counter.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command; high only in IDLE.
- `cmd_op` in 2: 00 LOAD, 01 UP, 10 DOWN, 11 HOLD.
- `cmd_arg` in WIDTH: LOAD value, or step/cycle count for UP/DOWN/HOLD.
- `max_count` in 1: counter output; counter is at all-ones.
- `zero` in 1: counter output; counter is at 0.
- `load_n` out 1: counter load, active-low.
- `ce` out 1: counter count enable.
- `up_down` out 1: 1 = up, 0 = down.
- `data_load` out WIDTH: counter load value.
- `busy` out 1: command in progress (state != IDLE).
- `done` out 1: one-cycle completion pulse.
- `sat_hit` out 1: one-cycle pulse; command was terminated by saturation.

## Operation
- Registers: `state` ∈ {IDLE, LOAD, RUN}, `op_q`, `arg_q`, `rem` (WIDTH bits), `done`, `sat_hit`.
- Handshake: a command is accepted on a rising edge where `cmd_valid && cmd_ready`. `cmd_op` / `cmd_arg` are captured into `op_q` / `arg_q`.
- IDLE:
  - Outputs: `load_n`=1, `ce`=0, `up_down`=0, `data_load`=0. The counter holds.
  - Accept LOAD → LOAD.
  - Accept UP/DOWN/HOLD with `cmd_arg`≠0 → RUN, `rem`=`cmd_arg`.
  - Accept UP/DOWN/HOLD with `cmd_arg`=0 → stay IDLE, `done`=1 next cycle, no control activity.
- LOAD:
  - For exactly one cycle, `load_n`=0 and `data_load`=`arg_q`; `ce`=0.
  - Next edge: → IDLE, `done`=1.
- RUN:
  - `up_down`=1 for UP, 0 otherwise.
  - `ce` = (op_q≠HOLD) && !sat, where sat = SATURATE && ((op_q==UP && `max_count`) || (op_q==DOWN && `zero`)).
  - `load_n`=1.
  - Each cycle, `rem` decrements.
  - When `rem`==1 or sat: next edge → IDLE, `done`=1, and `sat_hit`=sat.
- `ce`, `load_n`, `up_down` and `data_load` are decoded from registered state. The only combinational input path is `max_count`/`zero` → `ce`.
- Wrap (SATURATE=0): UP/DOWN steps are issued blindly and the counter wraps 15→0 or 0→15.
- `busy` = (state≠IDLE). `cmd_ready` = !`busy`.
- A new command may be accepted in the same cycle `done` is high.

## Timing
- Accept at edge k. Control drives in cycles k+1 .. k+N, where N is 1 for LOAD and `arg` for RUN (fewer if saturated).
- The counter updates on edges k+2 .. k+N+1.
- `done` is high in cycle k+N+1, when the final `count_out` is visible. `cmd_ready` is also high in that cycle.
- Zero-argument commands: `done` is high in cycle k+1.
- Saturation check uses the current-cycle `max_count`/`zero`. The terminating cycle drives `ce`=0, and `done` plus `sat_hit` follow in the next cycle.
- Reset (asynchronous, any state, including mid-RUN):
  - `state`=IDLE, `rem`=0.
  - Outputs: `load_n`=1, `ce`=0, `up_down`=0, `data_load`=0, `busy`=0, `done`=0, `sat_hit`=0, `cmd_ready`=1 once `rst_n` is released.
  - An aborted command produces no `done`.
- `cmd_valid` while busy is ignored; the command is not accepted until `cmd_ready`=1.

## Test plan
- LOAD 4'h9 accepted at edge k → `load_n`=0 and `data_load`=9 in cycle k+1 only; `done` in k+2 with counter=9.
- LOAD 3, then UP 5 → `ce`=1 and `up_down`=1 for 5 cycles; `done` with counter=8, `sat_hit`=0.
- SATURATE=1: LOAD 13, then UP 6 → `ce` high for 2 cycles, then `ce`=0 while `max_count`=1; `done` and `sat_hit` pulse; counter=15. Repeat with DOWN 4 from 2 → stops at 0 with `sat_hit`.
- SATURATE=0: LOAD 14, then UP 3 → counter=1 at `done`. HOLD 4 → `ce`=0 for 4 cycles, counter unchanged, `done` after 4.
- UP with arg 0 → `done` in the next cycle, no `ce`, `cmd_ready` stays 1. Back-to-back: new `cmd_valid` held during `done` is accepted that edge.
- Assert `rst_n`=0 mid-RUN (UP 10, after 3 steps) → all outputs at reset values immediately, no `done`. After release, a LOAD 7 completes normally.
